i2c_target_responder: RTL

- Synthesizable I2C target (responder) that answers the I2C master driven by the I2CMB core.
- Oversamples SCL/SDA on the system clock, detects START/STOP and matches its 7-bit address.
- ACKs and delivers written bytes on a byte-stream port; fetches read bytes through a request port.
- Sits on the I2C bus segment of the verification environment as the bus-side counterpart of the master, and doubles as a reusable RTL target for ASIC bring-up.

---
 rtl/i2c_types_pkg.sv | 31 +++
 rtl/i2c_line_sync.sv | 57 +++++
 rtl/i2c_target_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_types_pkg
// Description : Shared I2C types and widths. Transfer direction (i2c_op_t)
//               and the target responder's state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_types_pkg;

    localparam int I2C_ADDR_WIDTH = 7;
    localparam int I2C_DATA_WIDTH = 8;

    // Direction bit of the address byte (bit 0).
    typedef enum logic {
        I2_WRITE = 1'b0,
        I2_READ  = 1'b1
    } i2c_op_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_DATA  = 3'd3,
        WR_ACK   = 3'd4,
        RD_DATA  = 3'd5,
        RD_ACK   = 3'd6,
        IGNORE   = 3'd7
    } i2c_resp_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_sync
// Description : Synchronises SCL/SDA into the clk_i domain, adds one delay
//               flop per line and derives bus events.
// Ports       : clk_i, rst_i        - clock, async active-high reset
//               scl_i, sda_i        - raw (resolved) bus lines
//               scl_rise, scl_fall  - one-cycle edge strobes of synced SCL
//               start_det, stop_det - START / STOP condition strobes
//               sda_s               - synchronised SDA level
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_dly;
    logic                   r_sda_dly;
    logic                   w_scl_s;

    // Lines idle high, so flops reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_dly  <= 1'b1;
            r_sda_dly  <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_dly  <= w_scl_s;
            r_sda_dly  <= sda_s;
        end
    end

    assign w_scl_s   = r_scl_sync[SYNC_STAGES-1];
    assign sda_s     = r_sda_sync[SYNC_STAGES-1];
    assign scl_rise  = w_scl_s & ~r_scl_dly;
    assign scl_fall  = ~w_scl_s & r_scl_dly;
    // SCL must be high on both sides of the SDA transition.
    assign start_det = w_scl_s & r_scl_dly & r_sda_dly & ~sda_s;
    assign stop_det  = w_scl_s & r_scl_dly & ~r_sda_dly & sda_s;

endmodule
`default_nettype wire

// File: rtl/i2c_target_responder.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_responder
// Description : I2C target. Matches TGT_ADDR, ACKs/streams written bytes out
//               on wdata_o/wvalid_o and fetches read bytes via rd_req_o.
// Ports       : clk_i, rst_i         - clock, async active-high reset
//               scl_i, sda_i, sda_oe_o - bus lines, SDA pull-down enable
//               busy_o, op_o          - transfer active / direction
//               start_o, stop_o       - address ACKed / STOP while busy
//               wdata_o, wvalid_o, wr_full_i - write byte stream
//               rd_req_o, rdata_i, rd_nack_o - read byte fetch
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_responder
    import i2c_types_pkg::*;
#(
    parameter logic [I2C_ADDR_WIDTH-1:0] TGT_ADDR    = 7'h22,
    parameter int                        SYNC_STAGES = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_oe_o,
    output logic                      busy_o,
    output i2c_op_t                   op_o,
    output logic                      start_o,
    output logic                      stop_o,
    output logic [I2C_DATA_WIDTH-1:0] wdata_o,
    output logic                      wvalid_o,
    input  logic                      wr_full_i,
    output logic                      rd_req_o,
    input  logic [I2C_DATA_WIDTH-1:0] rdata_i,
    output logic                      rd_nack_o
);

    logic w_scl_rise, w_scl_fall, w_start_det, w_stop_det, w_sda_s;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start_det),
        .stop_det  (w_stop_det),
        .sda_s     (w_sda_s)
    );

    i2c_resp_state_t            r_state, w_state_nxt;
    logic [3:0]                 r_bit_cnt, w_bit_cnt_nxt;
    logic [I2C_DATA_WIDTH-1:0]  r_shift, w_shift_nxt;
    logic [I2C_DATA_WIDTH-1:0]  r_wdata, w_wdata_nxt;
    i2c_op_t                    r_op, w_op_nxt;
    logic r_sda_oe, w_sda_oe_nxt;
    logic r_busy, w_busy_nxt;
    logic r_load, w_load_nxt;
    logic r_start, w_start_nxt;
    logic r_stop, w_stop_nxt;
    logic r_wvalid, w_wvalid_nxt;
    logic r_rd_req, w_rd_req_nxt;
    logic r_rd_nack, w_rd_nack_nxt;

    logic w_byte_done;
    logic w_addr_match;

    assign w_byte_done  = (r_bit_cnt == 4'd8);
    assign w_addr_match = (r_shift[I2C_DATA_WIDTH-1:1] == TGT_ADDR);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; bus conditions pre-empt any same-cycle SCL edge.
    always_comb begin
        w_state_nxt = r_state;
        if (w_start_det) begin
            w_state_nxt = ADDR;
        end else if (w_stop_det) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                ADDR:     if (w_scl_fall && w_byte_done)
                              w_state_nxt = w_addr_match ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (w_scl_fall)
                              w_state_nxt = (r_op == I2_READ) ? RD_DATA : WR_DATA;
                WR_DATA:  if (w_scl_fall && w_byte_done) w_state_nxt = WR_ACK;
                WR_ACK:   if (w_scl_fall) w_state_nxt = WR_DATA;
                RD_DATA:  if (w_scl_fall && w_byte_done) w_state_nxt = RD_ACK;
                RD_ACK: begin
                    if (w_scl_rise && w_sda_s) w_state_nxt = IGNORE;
                    else if (w_scl_fall)       w_state_nxt = RD_DATA;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        // rdata_i is sampled one cycle after the rd_req_o pulse.
        w_shift_nxt   = r_load ? rdata_i : r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_sda_oe_nxt  = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_op_nxt      = r_op;
        w_wdata_nxt   = r_wdata;
        w_load_nxt    = r_rd_req;
        w_start_nxt   = 1'b0;
        w_stop_nxt    = 1'b0;
        w_wvalid_nxt  = 1'b0;
        w_rd_req_nxt  = 1'b0;
        w_rd_nack_nxt = 1'b0;
        if (w_start_det || w_stop_det) begin
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
            w_load_nxt    = 1'b0;
            w_stop_nxt    = w_stop_det & r_busy;
        end else begin
            case (r_state)
                ADDR, WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = {r_shift[I2C_DATA_WIDTH-2:0], w_sda_s};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && w_byte_done) begin
                        if (r_state == ADDR) begin
                            if (w_addr_match) begin
                                w_sda_oe_nxt = 1'b1;
                                w_op_nxt     = i2c_op_t'(r_shift[0]);
                                w_start_nxt  = 1'b1;
                                w_busy_nxt   = 1'b1;
                            end
                        end else if (!wr_full_i) begin
                            w_sda_oe_nxt = 1'b1;
                            w_wdata_nxt  = r_shift;
                            w_wvalid_nxt = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (w_scl_rise && r_op == I2_READ) begin
                        w_rd_req_nxt = 1'b1;
                    end else if (w_scl_fall) begin
                        // Read: MSB goes out on the same fall that ends the ACK.
                        w_sda_oe_nxt  = (r_op == I2_READ) ? ~r_shift[I2C_DATA_WIDTH-1] : 1'b0;
                        w_bit_cnt_nxt = (r_op == I2_READ) ? 4'd1 : 4'd0;
                    end
                end
                WR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt  = 1'b0;
                        w_bit_cnt_nxt = 4'd0;
                    end
                end
                RD_DATA: begin
                    // Counter holds bits already driven; shift left keeps the
                    // next bit at position 6.
                    if (w_scl_fall) begin
                        if (w_byte_done) begin
                            w_sda_oe_nxt = 1'b0;
                        end else begin
                            w_sda_oe_nxt  = ~r_shift[I2C_DATA_WIDTH-2];
                            w_shift_nxt   = {r_shift[I2C_DATA_WIDTH-2:0], 1'b0};
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda_s) begin
                            w_rd_nack_nxt = 1'b1;
                            w_busy_nxt    = 1'b0;
                        end else begin
                            w_rd_req_nxt  = 1'b1;
                        end
                    end else if (w_scl_fall) begin
                        w_sda_oe_nxt  = ~r_shift[I2C_DATA_WIDTH-1];
                        w_bit_cnt_nxt = 4'd1;
                    end
                end
                default: w_sda_oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bit_cnt <= 4'd0;
            r_shift   <= '0;
            r_wdata   <= '0;
            r_op      <= I2_WRITE;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_load    <= 1'b0;
            r_start   <= 1'b0;
            r_stop    <= 1'b0;
            r_wvalid  <= 1'b0;
            r_rd_req  <= 1'b0;
            r_rd_nack <= 1'b0;
        end else begin
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_wdata   <= w_wdata_nxt;
            r_op      <= w_op_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_load    <= w_load_nxt;
            r_start   <= w_start_nxt;
            r_stop    <= w_stop_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_rd_req  <= w_rd_req_nxt;
            r_rd_nack <= w_rd_nack_nxt;
        end
    end

    assign sda_oe_o  = r_sda_oe;
    assign busy_o    = r_busy;
    assign op_o      = r_op;
    assign start_o   = r_start;
    assign stop_o    = r_stop;
    assign wdata_o   = r_wdata;
    assign wvalid_o  = r_wvalid;
    assign rd_req_o  = r_rd_req;
    assign rd_nack_o = r_rd_nack;

endmodule
`default_nettype wire
